// File: rtl/qrd_slot_sequencer.sv
// Slot-level controller for the 4x4 Givens/CORDIC systolic QR array: CORDIC iteration
// counter, PE/DU load strobes, one-row-per-slot input handshake and output valid/row tagging.
module qrd_slot_sequencer #(
    parameter int ITER_SWITCH = 13,
    parameter int PIPE_SLOTS  = 4,
    parameter int NUM_ROWS    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] iter,
    output logic       pe_switch,
    output logic       pe_load,
    output logic       du_load,
    output logic       cordic_load,
    output logic [2:0] vec_flag,
    output logic       out_valid,
    output logic [1:0] out_row,
    output logic       out_last,
    output logic       busy,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    localparam logic [4:0] SWITCH_CNT = 5'(ITER_SWITCH);
    localparam logic [4:0] ACCEPT_CNT = 5'd30;
    localparam logic [4:0] LAST_CNT   = 5'd31;
    localparam logic [1:0] LAST_ROW   = 2'(NUM_ROWS - 1);

    state_t                state;
    state_t                state_nx;
    logic [4:0]            cnt;
    logic [4:0]            cnt_nx;
    logic [1:0]            in_row;
    logic [2:0]            vflag_r;
    logic [2:0]            vflag_nx;
    logic [PIPE_SLOTS-1:0] vld_sr;
    logic [1:0]            out_row_r;
    logic                  active;
    logic                  at_accept;
    logic                  at_bound;
    logic                  accept;

    // Handshake: a row transfers on any cycle where in_valid && in_ready. in_ready is
    // only ever high for the single cnt==30 cycle of a RUN slot and never depends on
    // in_valid; the front end holds its row stable until that transfer happens.
    always_comb begin
        active      = (state != IDLE);
        at_accept   = active && (cnt == ACCEPT_CNT);
        at_bound    = active && (cnt == LAST_CNT);
        in_ready    = (state == RUN) && (cnt == ACCEPT_CNT);
        accept      = in_valid && in_ready;
        pe_load     = at_bound;
        du_load     = at_accept;
        cordic_load = active && ((cnt == LAST_CNT) || (cnt == SWITCH_CNT));
        out_valid   = at_accept && vld_sr[PIPE_SLOTS-1];
        out_last    = out_valid && (out_row_r == LAST_ROW);
        iter        = cnt[3:0];
        pe_switch   = cnt[4];
        vec_flag    = vflag_r;
        out_row     = out_row_r;
        busy        = active;
        state_dbg   = state;
    end

    // The last matrix row never runs any PE in vectoring mode.
    always_comb begin
        vflag_nx = '0;
        for (int k = 0; k < 3; k++) begin
            if (k < NUM_ROWS - 1) begin
                vflag_nx[k] = accept && (in_row == 2'(k));
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (en) state_nx = RUN;
            RUN:  if (!en) state_nx = STOP;
            STOP: begin
                if (en) begin
                    state_nx = RUN;
                end else if ((cnt == LAST_CNT) && (vld_sr == '0)) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase

        // Counter skips ITER_SWITCH+1..15 so phase B always spans 16..31.
        if ((state == IDLE) || (state_nx == IDLE)) begin
            cnt_nx = 5'd0;
        end else if (cnt == SWITCH_CNT) begin
            cnt_nx = 5'd16;
        end else begin
            cnt_nx = cnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= 5'd0;
            in_row    <= 2'd0;
            vflag_r   <= 3'd0;
            vld_sr    <= '0;
            out_row_r <= 2'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (state == IDLE) begin
                in_row    <= 2'd0;
                vflag_r   <= 3'd0;
                vld_sr    <= '0;
                out_row_r <= 2'd0;
            end else if (at_accept) begin
                vflag_r <= vflag_nx;
                vld_sr  <= (vld_sr << 1) | PIPE_SLOTS'(accept);
                if (accept) begin
                    in_row <= (in_row == LAST_ROW) ? 2'd0 : in_row + 2'd1;
                end
                if (out_valid) begin
                    out_row_r <= (out_row_r == LAST_ROW) ? 2'd0 : out_row_r + 2'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_qrd_slot_sequencer.sv
// Bench for qrd_slot_sequencer: directed phases plus random traffic, every cycle compared
// against a slot-position model with a delay-line queue for rows in flight.
module tb_qrd_slot_sequencer;

    localparam int ITER_SWITCH = 13;
    localparam int PIPE_SLOTS  = 4;
    localparam int NUM_ROWS    = 4;
    localparam int SLOT        = ITER_SWITCH + 17;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] iter;
    logic       pe_switch;
    logic       pe_load;
    logic       du_load;
    logic       cordic_load;
    logic [2:0] vec_flag;
    logic       out_valid;
    logic [1:0] out_row;
    logic       out_last;
    logic       busy;
    logic [1:0] state_dbg;

    always #5 clk = ~clk;

    qrd_slot_sequencer #(
        .ITER_SWITCH(ITER_SWITCH),
        .PIPE_SLOTS (PIPE_SLOTS),
        .NUM_ROWS   (NUM_ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .iter       (iter),
        .pe_switch  (pe_switch),
        .pe_load    (pe_load),
        .du_load    (du_load),
        .cordic_load(cordic_load),
        .vec_flag   (vec_flag),
        .out_valid  (out_valid),
        .out_row    (out_row),
        .out_last   (out_last),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model: mode 0 idle, 1 running, 2 draining; pos is the cycle index inside a slot.
    int m_mode;
    int m_pos;
    int m_in_row;
    int m_vflag;
    int m_out_row;
    bit m_hist[$];
    int first_acc = -1;
    int first_ov  = -1;
    int ov_count  = 0;

    function automatic int cnt_of(int pos);
        return (pos <= ITER_SWITCH) ? pos : pos + 15 - ITER_SWITCH;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_in_row  = 0;
        m_vflag   = 0;
        m_out_row = 0;
        m_hist.delete();
        for (int i = 0; i < PIPE_SLOTS; i++) m_hist.push_back(1'b0);
    endtask

    task automatic check_outputs();
        int c;
        bit act;
        bit ov;
        act = (m_mode != 0);
        c   = act ? cnt_of(m_pos) : 0;
        ov  = act && (m_pos == SLOT - 2) && m_hist[0];
        check("busy",        32'(busy),        32'(act));
        check("iter",        32'(iter),        32'(c % 16));
        check("pe_switch",   32'(pe_switch),   32'(c / 16));
        check("pe_load",     32'(pe_load),     32'(act && m_pos == SLOT - 1));
        check("du_load",     32'(du_load),     32'(act && m_pos == SLOT - 2));
        check("cordic_load", 32'(cordic_load), 32'(act && (m_pos == SLOT - 1 || m_pos == ITER_SWITCH)));
        check("in_ready",    32'(in_ready),    32'(m_mode == 1 && m_pos == SLOT - 2));
        check("vec_flag",    32'(vec_flag),    32'(m_vflag));
        check("out_valid",   32'(out_valid),   32'(ov));
        check("out_row",     32'(out_row),     32'(m_out_row));
        check("out_last",    32'(out_last),    32'(ov && m_out_row == NUM_ROWS - 1));
        if (out_valid === 1'b1) begin
            ov_count++;
            if (first_ov < 0) first_ov = cyc;
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit v);
        bit acc;
        bit ov;
        bit any;
        bit to_idle;
        if (r) begin
            m_mode = 0;
            m_pos  = 0;
            model_clear();
            return;
        end
        if (m_mode == 0) begin
            model_clear();
            if (e) begin
                m_mode = 1;
                m_pos  = 0;
            end
            return;
        end
        if (m_pos == SLOT - 2) begin
            acc = (m_mode == 1) && v;
            ov  = m_hist.pop_front();
            m_hist.push_back(acc);
            m_vflag = (acc && m_in_row < NUM_ROWS - 1) ? (1 << m_in_row) : 0;
            if (acc) m_in_row = (m_in_row + 1) % NUM_ROWS;
            if (ov) m_out_row = (m_out_row + 1) % NUM_ROWS;
            if (acc && first_acc < 0) first_acc = cyc;
        end
        any = 1'b0;
        foreach (m_hist[i]) any |= m_hist[i];
        to_idle = 1'b0;
        if (m_mode == 1) begin
            if (!e) m_mode = 2;
        end else if (e) begin
            m_mode = 1;
        end else if (m_pos == SLOT - 1 && !any) begin
            to_idle = 1'b1;
        end
        if (to_idle) begin
            m_mode = 0;
            m_pos  = 0;
        end else begin
            m_pos = (m_pos + 1) % SLOT;
        end
    endtask

    task automatic tick(input bit r, input bit e, input bit v);
        check_outputs();
        rst      = r;
        en       = e;
        in_valid = v;
        model_step(r, e, v);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        bit en_r;
        int budget;
        rst      = 1'b1;
        en       = 1'b0;
        in_valid = 1'b0;
        m_mode   = 0;
        m_pos    = 0;
        model_clear();
        repeat (2) @(negedge clk);

        // Reset state.
        repeat (3) tick(1'b1, 1'b0, 1'b0);

        // Continuous input: strobe table, vec_flag rotation, first output latency.
        repeat (SLOT * 9) tick(1'b0, 1'b1, 1'b1);
        check("first_out_latency", 32'(first_ov - first_acc), 32'(PIPE_SLOTS * SLOT));

        // Random input with slot 2 fully starved (bubble).
        for (int s = 0; s < 8; s++)
            for (int c = 0; c < SLOT; c++)
                tick(1'b0, 1'b1, (s == 2) ? 1'b0 : ($urandom_range(0, 3) != 0));

        // Drop en after a couple of accepts and wait for the drain.
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        repeat (SLOT * 2 + 5) tick(1'b0, 1'b1, 1'b1);
        budget = SLOT * (PIPE_SLOTS + 3);
        while (budget > 0 && busy !== 1'b0) begin
            tick(1'b0, 1'b0, 1'b1);
            budget--;
        end
        check("drain_done", 32'(busy), 32'd0);
        repeat (10) tick(1'b0, 1'b0, 1'b1);

        // Re-enable while still draining: nothing in flight is lost.
        repeat (SLOT * 3) tick(1'b0, 1'b1, 1'b1);
        repeat (SLOT + 7) tick(1'b0, 1'b0, 1'b1);
        repeat (SLOT * 6) tick(1'b0, 1'b1, 1'b1);

        // Reset mid-slot at cnt==20 with rows in flight.
        budget = SLOT * 2;
        while (budget > 0 && !(m_mode != 0 && cnt_of(m_pos) == 20)) begin
            tick(1'b0, 1'b1, 1'b1);
            budget--;
        end
        check("rst_point_cnt", 32'(iter), 32'd4);
        tick(1'b1, 1'b1, 1'b1);
        ov_count = 0;
        repeat (SLOT * (PIPE_SLOTS + 2)) tick(1'b0, 1'b0, 1'b1);
        check("no_out_after_rst", 32'(ov_count), 32'd0);

        // Random traffic with occasional en toggles and resets.
        en_r = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 59) == 0) en_r = !en_r;
            tick($urandom_range(0, 699) == 0, en_r, $urandom_range(0, 1) == 1);
        end
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
